// File: rtl/mig_app_pkg.sv
// Shared definitions for the MIG user-application initiator.
// Holds the app_cmd codes, the data/mask/address widths, the state
// encoding of the initiator FSM and a small address-alignment helper.
package mig_app_pkg;

  localparam int DATA_W = 128;
  localparam int MASK_W = 16;
  localparam int ADDR_W = 28;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_WDAT  = 3'd2;
  localparam logic [2:0] ST_RWAIT = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // MIG addresses one 128-bit beat at a time, so the byte offset is dropped.
  function automatic logic [ADDR_W-1:0] beat_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:4], 4'h0};
  endfunction

endpackage

// File: rtl/mig_app_initiator_if.sv
// MIG user-application bus: command channel (app_addr/app_cmd/app_en/app_rdy),
// write-data channel (app_wdf_*) and read-data return (app_rd_*).
// modport master : the initiator (drives commands and write data)
// modport slave  : the MIG core or a simulation model of it
//
// Handshake: a command transfers in a cycle where app_en & app_rdy; a write
// beat transfers where app_wdf_wren & app_wdf_rdy. The initiator keeps
// app_en/app_addr/app_cmd (and wren/data/mask) stable until the transfer.
// app_rd_data_valid is a one-cycle strobe with no back-pressure.
interface mig_app_initiator_if;
  import mig_app_pkg::*;

  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_end;
  logic              app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_end,
           app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_end,
           app_rd_data_valid
  );

endinterface

// File: rtl/mig_app_initiator.sv
// Initiator side of the MIG user-application interface.
// Takes single-beat 128-bit read/write requests, issues them to the MIG one
// at a time and returns a response. A read that never returns data is
// answered with resp_err after TIMEOUT wait cycles.
//
// Ports:
//   mclk, mrst_n          clock, asynchronous active-low reset
//   req_*                 request channel (valid/ready), addr/data/mask
//   resp_*                response channel (valid/ready), write flag,
//                         timeout error, read data
//   app                   MIG application bus (master modport)
//   dbg_state             current FSM state, for observation only
//
// Request/response handshake: a request transfers when req_valid & req_ready,
// a response when resp_valid & resp_ready; resp_* fields are stable while
// resp_valid is high. All outputs come from registers or from the state
// register, so there is no combinational path from app_* inputs to outputs.
module mig_app_initiator
  import mig_app_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic              mclk,
  input  logic              mrst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  mig_app_initiator_if.master app,
  output logic [2:0]        dbg_state
);

  logic [2:0]        state;
  logic [2:0]        cmd_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [7:0]        wait_cnt;
  logic [7:0]        wait_cnt_inc;
  logic              expire;
  logic [4:0]        unused_bits;

  // wait_cnt counts completed read-wait cycles; the cycle that brings the
  // count to TIMEOUT is the last one waited. It saturates rather than wraps.
  assign wait_cnt_inc = (wait_cnt == TIMEOUT) ? wait_cnt : wait_cnt + 8'd1;
  assign expire       = (wait_cnt_inc == TIMEOUT);

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state    <= ST_IDLE;
      cmd_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= beat_align(req_addr);
            write_q <= req_write;
            cmd_q   <= req_write ? MIG_CMD_WRITE : MIG_CMD_READ;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            rdata_q <= '0;
            err_q   <= 1'b0;
            state   <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (app.app_rdy) begin
            wait_cnt <= '0;
            state    <= write_q ? ST_WDAT : ST_RWAIT;
          end
        end
        ST_WDAT: begin
          if (app.app_wdf_rdy) state <= ST_RESP;
        end
        ST_RWAIT: begin
          // Returned data takes priority over a simultaneous expiry.
          if (app.app_rd_data_valid) begin
            rdata_q <= app.app_rd_data;
            err_q   <= 1'b0;
            state   <= ST_RESP;
          end else if (expire) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_write = write_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

  assign app.app_en       = (state == ST_CMD);
  assign app.app_cmd      = cmd_q;
  assign app.app_addr     = addr_q;
  assign app.app_wdf_wren = (state == ST_WDAT);
  assign app.app_wdf_end  = (state == ST_WDAT);
  assign app.app_wdf_data = wdata_q;
  assign app.app_wdf_mask = wmask_q;

  assign dbg_state = state;

  // Single-beat transfers never need rd_data_end; the low address bits are
  // a byte offset inside the beat.
  assign unused_bits = {app.app_rd_data_end, req_addr[3:0]};

endmodule
